// File: rtl/capi_put_line_gather_if.sv
// Purpose : bundles the header, beat and line handshakes of capi_put_line_gather.
// Latency : n/a (wires only).
// Backpressure: n/a; slave = the gather block, master = whoever drives its inputs.
// Signals:
//   i_h_v/i_h_r/i_h_ea/i_h_off      stream header (start line address, byte offset)
//   i_v/i_r/i_d/i_c/i_e             aligned 16-byte put beats
//   o_v/o_r/o_ea/o_d/o_be/o_e       gathered 128-byte line toward the write-command generator
interface capi_put_line_gather_if #(
  parameter int EA_WIDTH = 57
);
  logic                i_h_v;
  logic                i_h_r;
  logic [EA_WIDTH-1:0] i_h_ea;
  logic [6:0]          i_h_off;
  logic                i_v;
  logic                i_r;
  logic [127:0]        i_d;
  logic [3:0]          i_c;
  logic                i_e;
  logic                o_v;
  logic                o_r;
  logic [EA_WIDTH-1:0] o_ea;
  logic [1023:0]       o_d;
  logic [127:0]        o_be;
  logic                o_e;

  // Drives headers, beats and line-ready; observes everything else.
  modport master (
    output i_h_v, i_h_ea, i_h_off, i_v, i_d, i_c, i_e, o_r,
    input  i_h_r, i_r, o_v, o_ea, o_d, o_be, o_e
  );

  // The gather block itself.
  modport slave (
    input  i_h_v, i_h_ea, i_h_off, i_v, i_d, i_c, i_e, o_r,
    output i_h_r, i_r, o_v, o_ea, o_d, o_be, o_e
  );
endinterface

// File: rtl/capi_put_line_gather.sv
// Purpose : gathers aligned 16-byte put beats into 128-byte lines with byte enables.
// Latency : last beat of a line accepted at t -> o_v at t+1; header at t -> first beat at t+1.
// Backpressure: i_r/i_h_r depend on state only; while o_r is low the line is held and no beats are taken.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   bus (slave)          header / beat / line handshakes (see capi_put_line_gather_if)
//   o_lines, o_partial   lines flushed, and lines flushed with some byte disabled
// Optional feature: define CAPI_PUT_GATHER_PERF_EN to build the two counters;
// otherwise they read constant zero and no counter flops exist.
module capi_put_line_gather #(
  parameter int EA_WIDTH  = 57,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  capi_put_line_gather_if.slave bus,
  output logic [CNT_WIDTH-1:0] o_lines,
  output logic [CNT_WIDTH-1:0] o_partial
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam logic [EA_WIDTH-1:0] EA_ONE = {{(EA_WIDTH-1){1'b0}}, 1'b1};

  state_t              state_q;
  state_t              state_nxt;

  logic                run_q;     // low only until the first clock after reset release
  logic [EA_WIDTH-1:0] ea_q;
  logic [2:0]          slot_q;
  logic [3:0]          lo_q;
  logic                first_q;
  logic [127:0]        be_q;
  logic                oe_q;
  logic [7:0][127:0]   buf_q;

  logic                hdr_fire;
  logic                beat_fire;
  logic                line_fire;
  logic                line_end;
  logic                h_rdy;
  logic                b_rdy;
  logic                l_vld;

  logic [3:0]          lo_eff;
  logic [3:0]          hi_eff;
  logic [15:0]         beat_mask;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, handshake outputs and transfer strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    h_rdy     = 1'b0;
    b_rdy     = 1'b0;
    l_vld     = 1'b0;
    hdr_fire  = 1'b0;
    beat_fire = 1'b0;
    line_fire = 1'b0;
    line_end  = 1'b0;
    case (state_q)
      S_IDLE: begin
        h_rdy    = run_q;
        hdr_fire = run_q & bus.i_h_v;
        if (hdr_fire) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        b_rdy     = 1'b1;
        beat_fire = bus.i_v;
        // A line closes on its eighth slot or on the stream's last beat.
        line_end  = (slot_q == 3'd7) | bus.i_e;
        if (beat_fire && line_end) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        l_vld     = 1'b1;
        line_fire = bus.o_r;
        if (line_fire) begin
          state_nxt = oe_q ? S_IDLE : S_FILL;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.i_h_r = h_rdy;
  assign bus.i_r   = b_rdy;
  assign bus.o_v   = l_vld;

  // ---------------------------------------------------------------------------
  // Byte range written by the current beat. Only the first beat of a stream
  // starts mid-slot; only the last beat can end early. When hi < lo the mask
  // is empty, which is legal and still produces a (fully disabled) line.
  // ---------------------------------------------------------------------------
  always_comb begin
    lo_eff    = first_q ? lo_q : 4'd0;
    hi_eff    = 4'd15;
    beat_mask = '0;
    if (bus.i_e && (bus.i_c != 4'd0)) begin
      hi_eff = bus.i_c - 4'd1;
    end
    for (int b = 0; b < 16; b++) begin
      beat_mask[b] = (4'(b) >= lo_eff) && (4'(b) <= hi_eff);
    end
  end

  // ---------------------------------------------------------------------------
  // Line control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q   <= 1'b0;
      ea_q    <= '0;
      slot_q  <= '0;
      lo_q    <= '0;
      first_q <= 1'b0;
      be_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (hdr_fire) begin
        ea_q    <= bus.i_h_ea;
        slot_q  <= bus.i_h_off[6:4];
        lo_q    <= bus.i_h_off[3:0];
        first_q <= 1'b1;
        be_q    <= '0;
      end
      if (beat_fire) begin
        be_q[{slot_q, 4'd0} +: 16] <= be_q[{slot_q, 4'd0} +: 16] | beat_mask;
        first_q <= 1'b0;
        if (line_end) begin
          oe_q <= bus.i_e;
        end else begin
          slot_q <= slot_q + 3'd1;
        end
      end
      // Stream continues into the next line; the address wraps naturally.
      if (line_fire && !oe_q) begin
        ea_q   <= ea_q + EA_ONE;
        slot_q <= 3'd0;
        be_q   <= '0;
      end
    end
  end

  // Line data buffer: no reset, unwritten slots keep stale data under be=0.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      buf_q[slot_q] <= bus.i_d;
    end
  end

  assign bus.o_ea = ea_q;
  assign bus.o_d  = buf_q;
  assign bus.o_be = be_q;
  assign bus.o_e  = oe_q;

  // ---------------------------------------------------------------------------
  // Performance counters (wrap, never saturate)
  // ---------------------------------------------------------------------------
`ifdef CAPI_PUT_GATHER_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] lines_q;
  logic [CNT_WIDTH-1:0] partial_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lines_q   <= '0;
      partial_q <= '0;
    end else if (line_fire) begin
      lines_q <= lines_q + CNT_ONE;
      if (be_q != {128{1'b1}}) begin
        partial_q <= partial_q + CNT_ONE;
      end
    end
  end

  assign o_lines   = lines_q;
  assign o_partial = partial_q;
`else
  assign o_lines   = '0;
  assign o_partial = '0;
`endif

endmodule

// File: tb/tb_capi_put_line_gather.sv
// Purpose : directed self-checking bench for capi_put_line_gather.
// Latency : n/a.
// Backpressure: o_r is driven low except for single-cycle line accepts or held low deliberately.
module tb_capi_put_line_gather;

  localparam int EA_W  = 57;
  localparam int CNT_W = 32;

  logic clk;
  logic reset_n;
  logic [CNT_W-1:0] o_lines;
  logic [CNT_W-1:0] o_partial;

  capi_put_line_gather_if #(.EA_WIDTH(EA_W)) bus ();

  capi_put_line_gather #(
    .EA_WIDTH (EA_W),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .o_lines  (o_lines),
    .o_partial(o_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int exp_lines;
  int exp_partial;
  int beat_no;
  logic [127:0] mdl [8];   // expected line buffer contents

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] bmask(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 128; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction

  task automatic send_hdr(input logic [EA_W-1:0] ea, input logic [6:0] off);
    int n;
    bus.i_h_v   = 1'b1;
    bus.i_h_ea  = ea;
    bus.i_h_off = off;
    n = 0;
    while (!bus.i_h_r && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("hdr_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    bus.i_h_v = 1'b0;
  endtask

  task automatic send_beat(input int slot, input logic e, input logic [3:0] c);
    int n;
    logic [127:0] d;
    beat_no++;
    d = {4{32'hB000_0000 + 32'(beat_no)}};
    bus.i_v = 1'b1;
    bus.i_d = d;
    bus.i_e = e;
    bus.i_c = c;
    n = 0;
    while (!bus.i_r && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk("beat_timeout", 128'd0, 128'd1);
    end else begin
      mdl[slot] = d;
    end
    @(posedge clk); #1;
    bus.i_v = 1'b0;
    bus.i_e = 1'b0;
  endtask

  task automatic expect_line(input logic [EA_W-1:0] ea, input logic [127:0] be, input logic e);
    int n;
    n = 0;
    while (!bus.o_v && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk("line_timeout", 128'd0, 128'd1);
      return;
    end
    chk("o_ea", 128'(bus.o_ea), 128'(ea));
    chk("o_be", bus.o_be, be);
    chk("o_e", 128'(bus.o_e), 128'(e));
    for (int k = 0; k < 8; k++) chk($sformatf("o_d[%0d]", k), bus.o_d[128*k +: 128], mdl[k]);
    bus.o_r = 1'b1;
    @(posedge clk); #1;
    bus.o_r = 1'b0;
`ifdef CAPI_PUT_GATHER_PERF_EN
    exp_lines++;
    if (be != {128{1'b1}}) exp_partial++;
`endif
    chk("o_lines", 128'(o_lines), 128'(exp_lines));
    chk("o_partial", 128'(o_partial), 128'(exp_partial));
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_lines = 0; exp_partial = 0; beat_no = 0;
    for (int k = 0; k < 8; k++) mdl[k] = '0;
    bus.i_h_v = 0; bus.i_h_ea = '0; bus.i_h_off = '0;
    bus.i_v = 0; bus.i_d = '0; bus.i_c = '0; bus.i_e = 0; bus.o_r = 0;
    reset_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_v", 128'(bus.o_v), 128'd0);
    chk("rst_i_r", 128'(bus.i_r), 128'd0);
    chk("rst_i_h_r", 128'(bus.i_h_r), 128'd0);
    chk("rst_o_be", bus.o_be, 128'd0);
    chk("rst_o_e", 128'(bus.o_e), 128'd0);
    chk("rst_o_ea", 128'(bus.o_ea), 128'd0);
    chk("rst_o_lines", 128'(o_lines), 128'd0);
    chk("rst_o_partial", 128'(o_partial), 128'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_i_h_r", 128'(bus.i_h_r), 128'd1);

    // Full aligned line
    send_hdr(57'h100, 7'h00);
    for (int k = 0; k < 8; k++) send_beat(k, k == 7, 4'd0);
    expect_line(57'h100, {128{1'b1}}, 1'b1);

    // Mid-line start, short tail: slot 2 lo 4, three beats, last c=5
    send_hdr(57'h55, 7'h24);
    send_beat(2, 1'b0, 4'd0);
    send_beat(3, 1'b0, 4'd0);
    send_beat(4, 1'b1, 4'd5);
    expect_line(57'h55, bmask(36, 68), 1'b1);

    // Stream crossing a line boundary
    send_hdr(57'h1FF, 7'h70);
    send_beat(7, 1'b0, 4'd0);
    expect_line(57'h1FF, bmask(112, 127), 1'b0);
    send_beat(0, 1'b0, 4'd0);
    send_beat(1, 1'b1, 4'd0);
    expect_line(57'h200, bmask(0, 31), 1'b1);

    // Single beat with an empty byte range (hi=3 < lo=10)
    send_hdr(57'h42, 7'h0A);
    send_beat(0, 1'b1, 4'd4);
    expect_line(57'h42, 128'd0, 1'b1);
    chk("back_to_idle", 128'(bus.i_h_r), 128'd1);

    // Offset 127 and all-ones address wrapping to zero
    send_hdr({EA_W{1'b1}}, 7'd127);
    send_beat(7, 1'b0, 4'd0);
    expect_line({EA_W{1'b1}}, bmask(127, 127), 1'b0);
    send_beat(0, 1'b1, 4'd1);
    expect_line(57'h0, bmask(0, 0), 1'b1);

    // Line held by o_r low while a beat is offered
    send_hdr(57'h300, 7'h00);
    for (int k = 0; k < 8; k++) send_beat(k, 1'b0, 4'd0);
    bus.i_v = 1'b1;
    bus.i_d = {4{32'hDEAD_BEEF}};
    for (int cyc = 0; cyc < 10; cyc++) begin
      chk("stall_i_r", 128'(bus.i_r), 128'd0);
      chk("stall_o_v", 128'(bus.o_v), 128'd1);
      for (int k = 0; k < 8; k++) chk("stall_o_d", bus.o_d[128*k +: 128], mdl[k]);
      @(posedge clk); #1;
    end
    bus.i_v = 1'b0;
    expect_line(57'h300, {128{1'b1}}, 1'b0);
    send_beat(0, 1'b1, 4'd0);
    expect_line(57'h301, bmask(0, 15), 1'b1);

    // Reset in the middle of a line
    send_hdr(57'h500, 7'h00);
    for (int k = 0; k < 4; k++) send_beat(k, 1'b0, 4'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_o_v", 128'(bus.o_v), 128'd0);
    chk("midrst_i_r", 128'(bus.i_r), 128'd0);
    chk("midrst_i_h_r", 128'(bus.i_h_r), 128'd0);
    exp_lines = 0;
    exp_partial = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst_i_h_r", 128'(bus.i_h_r), 128'd1);
    chk("postrst_o_v", 128'(bus.o_v), 128'd0);
    chk("postrst_o_be", bus.o_be, 128'd0);
    chk("postrst_o_lines", 128'(o_lines), 128'd0);
    send_hdr(57'h600, 7'h00);
    for (int k = 0; k < 8; k++) send_beat(k, k == 7, 4'd0);
    expect_line(57'h600, {128{1'b1}}, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
